// File: rtl/apb_timer_periph_if.sv
// APB bus bundle between the peripheral master and the timer slave.
// The master modport drives the request side; the slave returns PRDATA/PREADY.
interface apb_timer_periph_if #(
    parameter int ADDR_W = 32
) ();
    logic [ADDR_W-1:0] PADDR;
    logic [31:0]       PWDATA;
    logic              PWRITE;
    logic              PENABLE;
    logic              PSEL;
    logic [31:0]       PRDATA;
    logic              PREADY;

    modport master (
        output PADDR, PWDATA, PWRITE, PENABLE, PSEL,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PENABLE, PSEL,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_timer_periph.sv
// APB timer: 32-bit prescaled up-counter with auto-reload, UIF flag and one-shot mode.
// Define TIMER_IRQ_EN to build the IER register and the registered irq output.
module apb_timer_periph #(
    parameter int ADDR_W = 32
) (
    input  logic                PCLK,
    input  logic                PRESET,
    apb_timer_periph_if.slave   bus,
    output logic                irq
);
    localparam logic [2:0] IDX_CR  = 3'd0;
    localparam logic [2:0] IDX_PSC = 3'd1;
    localparam logic [2:0] IDX_ARR = 3'd2;
    localparam logic [2:0] IDX_CNT = 3'd3;
    localparam logic [2:0] IDX_SR  = 3'd4;
    localparam logic [2:0] IDX_IER = 3'd5;

    logic [31:0] r_psc;
    logic [31:0] r_arr;
    logic [31:0] r_cnt;
    logic [31:0] r_psc_cnt;
    logic [31:0] r_prdata;
    logic        r_en;
    logic        r_opm;
    logic        r_uif;
    logic        r_uie;
    logic        r_pready;
    logic        r_irq;

    logic [2:0]  w_idx;
    logic        w_access;
    logic        w_commit;
    logic        w_rd_capture;
    logic        w_wr_cr;
    logic        w_clr;
    logic        w_tick;
    logic        w_wrap;
    logic        w_uif_set;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_idx        = bus.PADDR[4:2];
    assign w_access     = bus.PSEL & bus.PENABLE;
    // Writes land on the edge that ends the PREADY cycle; reads sample one edge earlier.
    assign w_commit     = w_access & r_pready & bus.PWRITE;
    assign w_rd_capture = w_access & ~r_pready & ~bus.PWRITE;
    assign w_wr_cr      = w_commit & (w_idx == IDX_CR);
    assign w_clr        = w_wr_cr & bus.PWDATA[2];
    assign w_tick       = r_en & (r_psc_cnt >= r_psc);
    assign w_wrap       = w_tick & (r_cnt >= r_arr);
    assign w_uif_set    = w_wrap & ~w_clr;
    assign w_unused     = ^{bus.PADDR[ADDR_W-1:5], bus.PADDR[1:0]};

    assign bus.PREADY   = r_pready;
    assign bus.PRDATA   = r_prdata;
    assign irq          = r_irq;

    // Register read multiplexer.
    always_comb begin
        w_rdata = 32'h0000_0000;
        case (w_idx)
            IDX_CR:  w_rdata = {30'h0, r_opm, r_en};
            IDX_PSC: w_rdata = r_psc;
            IDX_ARR: w_rdata = r_arr;
            IDX_CNT: w_rdata = r_cnt;
            IDX_SR:  w_rdata = {31'h0, r_uif};
            IDX_IER: w_rdata = {31'h0, r_uie};
            default: w_rdata = 32'h0000_0000;
        endcase
    end

    // APB handshake: one fixed wait state, PRDATA held until the next read.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_pready <= 1'b0;
            r_prdata <= 32'h0000_0000;
        end else begin
            r_pready <= w_access & ~r_pready;
            if (w_rd_capture) begin
                r_prdata <= w_rdata;
            end
        end
    end

    // Prescaler and main counter; a CLR write beats any tick in the same cycle.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_cnt     <= 32'h0000_0000;
            r_psc_cnt <= 32'h0000_0000;
        end else if (w_clr) begin
            r_cnt     <= 32'h0000_0000;
            r_psc_cnt <= 32'h0000_0000;
        end else if (w_tick) begin
            r_psc_cnt <= 32'h0000_0000;
            r_cnt     <= w_wrap ? 32'h0000_0000 : r_cnt + 32'd1;
        end else if (r_en) begin
            r_psc_cnt <= r_psc_cnt + 32'd1;
        end
    end

    // Control register; one-shot mode drops EN on the wrap unless CR is being written.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_en  <= 1'b0;
            r_opm <= 1'b0;
        end else if (w_wr_cr) begin
            r_en  <= bus.PWDATA[0];
            r_opm <= bus.PWDATA[1];
        end else if (w_uif_set && r_opm) begin
            r_en  <= 1'b0;
        end
    end

    // Prescaler and reload values, live from the cycle after the write.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_psc <= 32'h0000_0000;
            r_arr <= 32'h0000_0000;
        end else begin
            if (w_commit && (w_idx == IDX_PSC)) begin
                r_psc <= bus.PWDATA;
            end
            if (w_commit && (w_idx == IDX_ARR)) begin
                r_arr <= bus.PWDATA;
            end
        end
    end

    // Update flag: a hardware set wins over a coincident W1C.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_uif <= 1'b0;
        end else if (w_uif_set) begin
            r_uif <= 1'b1;
        end else if (w_commit && (w_idx == IDX_SR) && bus.PWDATA[0]) begin
            r_uif <= 1'b0;
        end
    end

`ifdef TIMER_IRQ_EN
    // Interrupt enable and registered interrupt line.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_uie <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            if (w_commit && (w_idx == IDX_IER)) begin
                r_uie <= bus.PWDATA[0];
            end
            r_irq <= r_uif & r_uie;
        end
    end
`else
    assign r_uie = 1'b0;
    assign r_irq = 1'b0;
`endif
endmodule

// File: tb/tb_apb_timer_periph.sv
// Scoreboard bench for apb_timer_periph: expected values are queued, then popped on DUT output.
module tb_apb_timer_periph;
`ifdef TIMER_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif
    localparam logic [31:0] A_CR  = 32'h00, A_PSC = 32'h04, A_ARR = 32'h08;
    localparam logic [31:0] A_CNT = 32'h0C, A_SR  = 32'h10, A_IER = 32'h14;

    logic PCLK;
    logic PRESET;
    logic irq;
    apb_timer_periph_if #(.ADDR_W(32)) bus ();

    apb_timer_periph #(.ADDR_W(32)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus),
        .irq    (irq)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ev;
    logic [31:0] rd;
    int          lat;

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // One APB transfer starting k idle cycles from now; lat counts cycles from PSEL rise.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input int k, output logic [31:0] rdata, output int lt);
        bit done;
        repeat (k) @(posedge PCLK);
        @(posedge PCLK); #1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr;
        bus.PADDR = addr; bus.PWDATA = wdata;
        lt = 1;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        lt = 2;
        rdata = 32'hxxxx_xxxx;
        done = 1'b0;
        while (!done) begin
            @(negedge PCLK);
            if (bus.PREADY) begin
                rdata = bus.PRDATA;
                done = 1'b1;
            end else if (lt >= 16) begin
                n_checks++;
                $display("FAIL apb_timeout: PREADY=%b after %0d cycles, required 1 by cycle 3", bus.PREADY, lt);
                lt = 99;
                done = 1'b1;
            end else begin
                @(posedge PCLK); #1;
                lt++;
            end
        end
        @(posedge PCLK); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, input int k);
        logic [31:0] d;
        int l;
        apb_xfer(1'b1, addr, data, k, d, l);
    endtask

    task automatic apb_read(input logic [31:0] addr, input int k, output logic [31:0] data, output int l);
        apb_xfer(1'b0, addr, 32'h0, k, data, l);
    endtask

    // Stop the counter, clear state and flag, then load prescaler and reload.
    task automatic prep(input logic [31:0] psc, input logic [31:0] arr);
        apb_write(A_CR, 32'h4, 0);
        apb_write(A_SR, 32'h1, 0);
        apb_write(A_PSC, psc, 0);
        apb_write(A_ARR, arr, 0);
    endtask

    task automatic test_reset;
        PRESET = 1'b0;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = 32'h0; bus.PWDATA = 32'h0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        exp_q.push_back(32'h0);
        n_checks++; ev = exp_q.pop_front();
        if ({bus.PRDATA, bus.PREADY, irq} !== {ev, 2'b00})
            $display("FAIL reset_outputs: prdata=%h pready=%b irq=%b, required all 0", bus.PRDATA, bus.PREADY, irq);
        else n_pass++;
        @(posedge PCLK); #1 PRESET = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(32'h0);
            apb_read(i * 4, 0, rd, lat);
            n_checks++; ev = exp_q.pop_front();
            if (rd !== ev) $display("FAIL reset_read_%0d: got %h required %h", i, rd, ev);
            else n_pass++;
            n_checks++;
            if (lat !== 3) $display("FAIL pready_latency_%0d: got %0d required 3", i, lat);
            else n_pass++;
        end
        apb_write(A_CNT, 32'h55, 0);
        apb_write(32'h18, 32'hFFFF_FFFF, 0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        apb_read(A_CNT, 0, rd, lat);
        n_checks++; ev = exp_q.pop_front();
        if (rd !== ev) $display("FAIL cnt_readonly: got %h required %h", rd, ev); else n_pass++;
        apb_read(32'h18, 0, rd, lat);
        n_checks++; ev = exp_q.pop_front();
        if (rd !== ev) $display("FAIL reserved_read: got %h required %h", rd, ev); else n_pass++;
    endtask

    task automatic test_abort;
        @(posedge PCLK); #1;
        bus.PSEL = 1'b1; bus.PWRITE = 1'b1; bus.PADDR = A_PSC; bus.PWDATA = 32'hAB;
        @(posedge PCLK); #1 bus.PENABLE = 1'b1;
        @(posedge PCLK); #1;
        exp_q.push_back(32'h1);
        n_checks++; ev = exp_q.pop_front();
        if ({31'h0, bus.PREADY} !== ev) $display("FAIL abort_pready_high: got %b required 1", bus.PREADY);
        else n_pass++;
        PRESET = 1'b0;
        #1;
        exp_q.push_back(32'h0);
        n_checks++; ev = exp_q.pop_front();
        if ({31'h0, bus.PREADY} !== ev) $display("FAIL abort_pready_drop: got %b required 0", bus.PREADY);
        else n_pass++;
        @(posedge PCLK); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        PRESET = 1'b1;
        exp_q.push_back(32'h0);
        apb_read(A_PSC, 0, rd, lat);
        n_checks++; ev = exp_q.pop_front();
        if (rd !== ev) $display("FAIL abort_no_commit: PSC got %h required %h", rd, ev); else n_pass++;
    endtask

    // Enable commits at edge E0; a read with k idles captures state after edge E(k+2).
    task automatic test_count;
        logic [31:0] addrs [4];
        int          ks    [4];
        prep(32'd3, 32'd4);
        apb_write(A_CR, 32'h1, 0);
        addrs = '{A_SR, A_CNT, A_SR, A_CNT};
        ks    = '{17, 0, 0, 0};
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h2);
        for (int i = 0; i < 4; i++) begin
            apb_read(addrs[i], ks[i], rd, lat);
            n_checks++; ev = exp_q.pop_front();
            if (rd !== ev) $display("FAIL count_step_%0d: got %h required %h", i, rd, ev);
            else n_pass++;
        end
    endtask

    task automatic test_opm;
        logic [31:0] addrs [4];
        int          ks    [4];
        prep(32'd3, 32'd4);
        apb_write(A_CR, 32'h3, 0);
        addrs = '{A_CR, A_CNT, A_CNT, A_SR};
        ks    = '{20, 0, 100, 0};
        exp_q.push_back(32'h2);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1);
        for (int i = 0; i < 4; i++) begin
            apb_read(addrs[i], ks[i], rd, lat);
            n_checks++; ev = exp_q.pop_front();
            if (rd !== ev) $display("FAIL opm_step_%0d: got %h required %h", i, rd, ev);
            else n_pass++;
        end
    endtask

    task automatic test_w1c_race;
        prep(32'd3, 32'd4);
        apb_write(A_CR, 32'h1, 0);
        apb_write(A_SR, 32'h1, 16);
        exp_q.push_back(32'h1);
        apb_read(A_SR, 0, rd, lat);
        n_checks++; ev = exp_q.pop_front();
        if (rd !== ev) $display("FAIL w1c_race_set_wins: got %h required %h", rd, ev); else n_pass++;
        apb_write(A_SR, 32'h1, 0);
        exp_q.push_back(32'h0);
        apb_read(A_SR, 0, rd, lat);
        n_checks++; ev = exp_q.pop_front();
        if (rd !== ev) $display("FAIL w1c_clear: got %h required %h", rd, ev); else n_pass++;
    endtask

    task automatic test_clr;
        prep(32'd3, 32'd100);
        apb_write(A_CR, 32'h1, 0);
        apb_write(A_CR, 32'h5, 26);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1);
        apb_read(A_CNT, 0, rd, lat);
        n_checks++; ev = exp_q.pop_front();
        if (rd !== ev) $display("FAIL clr_cnt: got %h required %h", rd, ev); else n_pass++;
        apb_read(A_CR, 0, rd, lat);
        n_checks++; ev = exp_q.pop_front();
        if (rd !== ev) $display("FAIL clr_cr_readback: got %h required %h", rd, ev); else n_pass++;
    endtask

    task automatic test_arr_lower;
        logic [31:0] addrs [3];
        prep(32'd3, 32'd100);
        apb_write(A_CR, 32'h1, 0);
        apb_write(A_ARR, 32'd2, 24);
        addrs = '{A_CNT, A_CNT, A_SR};
        exp_q.push_back(32'd7);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        for (int i = 0; i < 3; i++) begin
            apb_read(addrs[i], 0, rd, lat);
            n_checks++; ev = exp_q.pop_front();
            if (rd !== ev) $display("FAIL arr_lower_step_%0d: got %h required %h", i, rd, ev);
            else n_pass++;
        end
    endtask

    task automatic test_irq;
        prep(32'd3, 32'd4);
        apb_write(A_IER, 32'h1, 0);
        exp_q.push_back({31'h0, IRQ_ON});
        apb_read(A_IER, 0, rd, lat);
        n_checks++; ev = exp_q.pop_front();
        if (rd !== ev) $display("FAIL ier_read: got %h required %h", rd, ev); else n_pass++;
        apb_write(A_CR, 32'h1, 0);
        exp_q.push_back(32'h0);
        exp_q.push_back({31'h0, IRQ_ON});
        exp_q.push_back({31'h0, IRQ_ON});
        exp_q.push_back(32'h0);
        repeat (20) @(posedge PCLK);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) apb_write(A_SR, 32'h1, 0);
            else if (i != 0) @(posedge PCLK);
            @(negedge PCLK);
            n_checks++; ev = exp_q.pop_front();
            if ({31'h0, irq} !== ev) $display("FAIL irq_step_%0d: got %b required %b", i, irq, ev[0]);
            else n_pass++;
        end
        apb_write(A_CR, 32'h4, 0);
    endtask

    initial begin
        test_reset();
        test_abort();
        test_count();
        test_opm();
        test_w1c_race();
        test_clr();
        test_arr_lower();
        test_irq();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/apb_timer_periph.md
# apb_timer_periph

APB slave timer peripheral on the MCU peripheral bus, alongside RAM and GPIO, driven by one of the APB master's PSELx/PRDATAx/PREADYx slots. Provides a 32-bit prescaled up-counter with auto-reload, an update flag, and one-shot mode. Firmware on the RV32I core programs and polls it through memory-mapped registers. An optional interrupt output is compiled in by macro.

## Interface
- ADDR_W, 32: PADDR width; only PADDR[4:2] is decoded.
- PCLK  input  1  bus and counter clock.
- PRESET  input  1  reset; asynchronous, active-low.
- PADDR  input  ADDR_W  byte address; the word index is PADDR[4:2].
- PWDATA  input  32  write data.
- PWRITE  input  1  1 = write, 0 = read.
- PENABLE  input  1  APB access phase.
- PSEL  input  1  slave select from the APB master.
- PRDATA  output  32  read data; valid while PREADY=1.
- PREADY  output  1  transfer-complete strobe.
- irq  output  1  timer interrupt (see Configuration).

## Operation
- Register map (word offsets):
  - 0x00 CR: bit0 EN, bit1 OPM, bit2 CLR.
    - CLR is write-only and self-clearing; it reads as 0.
  - 0x04 PSC: 32-bit prescaler.
  - 0x08 ARR: 32-bit auto-reload.
  - 0x0C CNT: counter, read-only. Writes are ignored.
  - 0x10 SR: bit0 UIF. Writing 1 clears it (W1C).
  - 0x14 IER: bit0 UIE.
  - Offsets 0x18/0x1C read 0; writes to them are ignored.
- Prescaler: internal psc_cnt[31:0] increments each PCLK while EN=1.
  - When psc_cnt ≥ PSC: psc_cnt←0 and a one-cycle tick is generated.
  - PSC=0 gives a tick every cycle.
- Counter, on each tick:
  - If CNT ≥ ARR: CNT←0 and UIF←1. If OPM=1, EN←0 in the same cycle.
  - Otherwise CNT←CNT+1.
  - ARR=0 keeps CNT at 0 and sets UIF every tick.
  - Comparison uses ≥, so lowering ARR below CNT while running wraps on the next tick.
- EN=0 freezes psc_cnt and CNT. They are not cleared.
- A CR write with CLR=1 zeroes CNT and psc_cnt at the commit edge. This overrides any tick in that cycle. EN/OPM are taken from the same write.
- Simultaneous SR W1C and hardware UIF set: the set wins and UIF stays 1.
- PSC/ARR writes take effect on the cycle after commit. There is no shadow register.

## Timing
- Reset (PRESET=0, async) clears all of the following to 0:
  - CR, PSC, ARR, CNT, SR, IER, psc_cnt.
  - Outputs PRDATA, PREADY, irq.
- APB handshake: fixed one wait state.
  - Setup cycle: PSEL=1, PENABLE=0. PREADY=0.
  - Access cycle 1: PSEL=1, PENABLE=1. PREADY=0.
  - Access cycle 2: PREADY=1, PRDATA valid.
    - Writes commit at the rising edge that ends this cycle.
  - PREADY is registered: PREADY ← PSEL & PENABLE & ~PREADY.
    - It is therefore a single-cycle pulse and never high in back-to-back cycles.
- PRDATA is registered alongside PREADY and holds its value until the next read.
- A CNT read returns the value at the end of access cycle 1.
- Reset asserted mid-transfer aborts it. PREADY returns low immediately and no write commits.
- irq is registered: it rises one cycle after UIF and UIE are both 1.

## Configuration
- TIMER_IRQ_EN defined:
  - IER is implemented.
  - irq = registered (UIF & UIE). irq stays high until UIF is cleared.
- TIMER_IRQ_EN undefined:
  - IER reads 0 and writes to it are ignored.
  - irq is tied to 0.
  - The port remains present so the MCU top-level netlist is unchanged.

## Test plan
- Reset, then read all six registers → each returns 0x0000_0000. Every access completes with PREADY high on exactly the 3rd cycle after PSEL rises.
- PSC=3, ARR=4, CR=0x1 → CNT advances every 4 PCLK. UIF=1 twenty cycles after enable. CNT returns to 0 and keeps counting.
- Same setup with CR=0x3 (OPM) → after the first wrap, CNT=0 and CR reads 0x2. CNT remains 0 for 100 further cycles.
- W1C on SR during the cycle that sets UIF → SR reads 0x1 afterwards. A later W1C without a coincident set → SR reads 0x0.
- Running with CNT=7, write CR=0x5 (EN|CLR) → next CNT read is ≤1 and CR reads 0x1. Separately, write ARR=2 while CNT=7 → wrap occurs on the next tick.
- With TIMER_IRQ_EN, IER=1 and the first wrap → irq rises one cycle after UIF and drops one cycle after SR is cleared. Without the macro → irq stays 0 and IER reads 0.
